// File: rtl/byte_fifo_interleaved_pkg.sv
// Shared sizing, bank write payload and byte-lane helper for the byte-interleaved TX FIFO.
package byte_fifo_interleaved_pkg;

  localparam int unsigned FifoEntryWidthBits = 32;
  localparam int unsigned FifoEntryWidthSize = 2;
  localparam int unsigned FifoDepthBytes     = 64;

  localparam int unsigned NumBanks  = 1 << FifoEntryWidthSize;
  localparam int unsigned PtrW      = $clog2(FifoDepthBytes);
  localparam int unsigned CountW    = PtrW + 1;
  localparam int unsigned BankSelW  = FifoEntryWidthSize;
  localparam int unsigned RowW      = PtrW - BankSelW;
  localparam int unsigned BankDepth = FifoDepthBytes / NumBanks;
  localparam int unsigned WidthW    = FifoEntryWidthSize + 1;

  // One bank's write request for the current cycle.
  typedef struct packed {
    logic            en;
    logic [RowW-1:0] row;
    logic [7:0]      data;
  } bank_wr_t;

  // Byte k of a right-aligned entry of 'width' bytes, MSB first.
  function automatic logic [7:0] entry_byte(input logic [FifoEntryWidthBits-1:0] data,
                                            input logic [WidthW-1:0]             width,
                                            input logic [WidthW-1:0]             k);
    logic [WidthW-1:0] sel;
    sel = width - k - WidthW'(1);
    return 8'(data >> {sel, 3'b000});
  endfunction

endpackage

// File: rtl/byte_fifo_interleaved_bank.sv
// One byte-wide storage bank: synchronous write, asynchronous read, no reset on contents.
//   clk   : clock
//   we    : write enable
//   waddr : write row
//   wdata : write byte
//   raddr : read row
//   rdata : read byte (combinational)
module byte_fifo_interleaved_bank
  import byte_fifo_interleaved_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [RowW-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [RowW-1:0] raddr,
  output logic [7:0]      rdata
);

  logic [7:0] mem [BankDepth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/byte_fifo_interleaved.sv
// Byte-granular transmit FIFO: 1-4 byte pushes per cycle, one byte popped per ack,
// first-word-fall-through head byte. Storage is split over byte-interleaved banks so
// any write lands in one cycle regardless of alignment.
//   clk_i        : clock
//   reset_i      : asynchronous active-high reset
//   write_enable : push request
//   write_data   : right-aligned entry, MSB byte first
//   write_width  : byte count of the entry (legal 1..4)
//   ack          : consumer took data_o, pop one byte
//   data_o       : head byte (0 while empty)
//   empty_o      : no bytes stored
//   full_o       : fewer than one full entry of space left
//   count_o      : stored byte count
module byte_fifo_interleaved
  import byte_fifo_interleaved_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          write_enable,
  input  logic [FifoEntryWidthBits-1:0] write_data,
  input  logic [WidthW-1:0]             write_width,
  input  logic                          ack,
  output logic [7:0]                    data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [CountW-1:0]             count_o
);

  logic [PtrW-1:0]     wr_ptr;
  logic [PtrW-1:0]     rd_ptr;
  logic [CountW-1:0]   count_next;
  logic                wr_accept;
  logic                rd_fire;
  logic [RowW-1:0]     wr_row;
  logic [BankSelW-1:0] wr_bank;
  logic [RowW-1:0]     rd_row;
  logic [BankSelW-1:0] rd_bank;
  bank_wr_t            bank_wr    [NumBanks];
  logic [7:0]          bank_rdata [NumBanks];

  assign wr_row  = wr_ptr[PtrW-1:BankSelW];
  assign wr_bank = wr_ptr[BankSelW-1:0];
  assign rd_row  = rd_ptr[PtrW-1:BankSelW];
  assign rd_bank = rd_ptr[BankSelW-1:0];

  // Acceptance uses the pre-pop count; an illegal or overflowing write is dropped whole.
  always_comb begin
    wr_accept = 1'b0;
    if (write_enable &&
        (write_width != '0) &&
        (write_width <= WidthW'(NumBanks)) &&
        (({1'b0, count_o} + (CountW+1)'(write_width)) <= (CountW+1)'(FifoDepthBytes))) begin
      wr_accept = 1'b1;
    end
    rd_fire    = ack && !empty_o;
    count_next = count_o
               + (wr_accept ? CountW'(write_width) : CountW'(0))
               - CountW'(rd_fire);
  end

  // Rotate entry bytes onto banks; banks below the start bank receive the wrapped tail
  // and therefore write one row further on.
  always_comb begin
    logic [BankSelW-1:0] lane;
    lane = '0;
    for (int b = 0; b < NumBanks; b++) begin
      lane       = BankSelW'(b) - wr_bank;
      bank_wr[b] = '0;
      if (wr_accept && (WidthW'(lane) < write_width)) begin
        bank_wr[b].en   = 1'b1;
        bank_wr[b].row  = wr_row + RowW'(BankSelW'(b) < wr_bank);
        bank_wr[b].data = entry_byte(write_data, write_width, WidthW'(lane));
      end
    end
  end

  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    byte_fifo_interleaved_bank u_bank (
      .clk   (clk_i),
      .we    (bank_wr[g].en),
      .waddr (bank_wr[g].row),
      .wdata (bank_wr[g].data),
      .raddr (rd_row),
      .rdata (bank_rdata[g])
    );
  end

  // Head byte straight from the bank holding rd_ptr; forced to 0 while empty.
  assign data_o = empty_o ? 8'h00 : bank_rdata[rd_bank];

  // Pointers, count and status flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PtrW'(write_width);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      count_o <= count_next;
      empty_o <= (count_next == '0);
      full_o  <= (count_next > CountW'(FifoDepthBytes - NumBanks));
    end
  end

endmodule

// File: tb/tb_byte_fifo_interleaved.sv
module tb_byte_fifo_interleaved;

  logic        clk_i;
  logic        reset_i;
  logic        write_enable;
  logic [31:0] write_data;
  logic [2:0]  write_width;
  logic        ack;
  logic [7:0]  data_o;
  logic        empty_o;
  logic        full_o;
  logic [6:0]  count_o;

  int errors;
  int checks;

  byte_fifo_interleaved dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_width  (write_width),
    .ack          (ack),
    .data_o       (data_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d, input logic [2:0] w);
    write_enable = 1'b1;
    write_data   = d;
    write_width  = w;
    tick();
    write_enable = 1'b0;
    write_data   = '0;
    write_width  = '0;
  endtask

  task automatic pop_one();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
    checks++; if (count_o !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_o); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_word_order();
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(32'hDEADBEEF, 3'd4);
    checks++; if (count_o !== 7'd4) begin errors++; $display("FAIL word_count got=%0d exp=4", count_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL word_empty got=%b exp=0", empty_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_o !== exp[i]) begin errors++; $display("FAIL word_byte%0d got=%h exp=%h", i, data_o, exp[i]); end
      pop_one();
      tick();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL word_drained_empty got=%b exp=1", empty_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL word_drained_data got=%h exp=00", data_o); end
  endtask

  task automatic test_mixed_widths();
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(32'h000000DE, 3'd1);
    do_write(32'h0000ADBE, 3'd2);
    do_write(32'h000000EF, 3'd1);
    checks++; if (count_o !== 7'd4) begin errors++; $display("FAIL mixed_count got=%0d exp=4", count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_o !== exp[i]) begin errors++; $display("FAIL mixed_byte%0d got=%h exp=%h", i, data_o, exp[i]); end
      pop_one();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mixed_empty got=%b exp=1", empty_o); end
  endtask

  // Misalign the pointers by one byte so the next word spans a bank wrap.
  task automatic test_rotation();
    logic [7:0] exp [4];
    exp = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_write(32'h00000099, 3'd1);
    checks++; if (data_o !== 8'h99) begin errors++; $display("FAIL rot_pad got=%h exp=99", data_o); end
    pop_one();
    do_write(32'h12345678, 3'd4);
    checks++; if (count_o !== 7'd4) begin errors++; $display("FAIL rot_count got=%0d exp=4", count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_o !== exp[i]) begin errors++; $display("FAIL rot_byte%0d got=%h exp=%h", i, data_o, exp[i]); end
      pop_one();
      tick();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rot_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_full();
    logic [7:0] b;
    for (int i = 0; i < 15; i++) begin
      b = 8'(4 * i);
      do_write({b, b + 8'd1, b + 8'd2, b + 8'd3}, 3'd4);
    end
    checks++; if (count_o !== 7'd60) begin errors++; $display("FAIL full_count60 got=%0d exp=60", count_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL full_at60 got=%b exp=0", full_o); end
    do_write(32'h00003C3D, 3'd2);
    checks++; if (count_o !== 7'd62) begin errors++; $display("FAIL full_count62 got=%0d exp=62", count_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_at62 got=%b exp=1", full_o); end
    do_write(32'hCAFEF00D, 3'd4);
    checks++; if (count_o !== 7'd62) begin errors++; $display("FAIL full_drop4 got=%0d exp=62", count_o); end
    do_write(32'h00003E3F, 3'd2);
    checks++; if (count_o !== 7'd64) begin errors++; $display("FAIL full_count64 got=%0d exp=64", count_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_at64 got=%b exp=1", full_o); end
    do_write(32'h000000AA, 3'd1);
    checks++; if (count_o !== 7'd64) begin errors++; $display("FAIL full_drop1 got=%0d exp=64", count_o); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (data_o !== 8'(i)) begin errors++; $display("FAIL full_drain%0d got=%h exp=%h", i, data_o, 8'(i)); end
      pop_one();
    end
    checks++; if (count_o !== 7'd0) begin errors++; $display("FAIL full_drained_count got=%0d exp=0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL full_drained_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [7];
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0, 8'hB1, 8'hB2};
    do_write(32'hA0A1A2A3, 3'd4);
    do_write(32'h000000A4, 3'd1);
    checks++; if (count_o !== 7'd5) begin errors++; $display("FAIL sim_count5 got=%0d exp=5", count_o); end
    ack = 1'b1;
    do_write(32'h00B0B1B2, 3'd3);
    checks++; if (count_o !== 7'd7) begin errors++; $display("FAIL sim_count7 got=%0d exp=7", count_o); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (data_o !== exp[i]) begin errors++; $display("FAIL sim_byte%0d got=%h exp=%h", i, data_o, exp[i]); end
      tick();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL sim_empty got=%b exp=1", empty_o); end
    tick();
    ack = 1'b0;
    checks++; if (count_o !== 7'd0) begin errors++; $display("FAIL sim_ack_empty got=%0d exp=0", count_o); end
    do_write(32'h00000055, 3'd0);
    checks++; if (count_o !== 7'd0) begin errors++; $display("FAIL sim_w0 got=%0d exp=0", count_o); end
    do_write(32'h11223344, 3'd5);
    checks++; if (count_o !== 7'd0) begin errors++; $display("FAIL sim_w5 got=%0d exp=0", count_o); end
    write_data  = 32'h11223344;
    write_width = 3'd4;
    tick();
    write_width = '0;
    write_data  = '0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL sim_no_enable got=%b exp=1", empty_o); end
  endtask

  task automatic test_async_reset();
    do_write(32'hDEADBEEF, 3'd4);
    pop_one();
    checks++; if (data_o !== 8'hAD) begin errors++; $display("FAIL ar_pre got=%h exp=AD", data_o); end
    #2;
    reset_i = 1'b1;
    #1;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ar_empty got=%b exp=1", empty_o); end
    checks++; if (count_o !== 7'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", count_o); end
    tick();
    reset_i = 1'b0;
    tick();
    do_write(32'h000000AB, 3'd1);
    checks++; if (data_o !== 8'hAB) begin errors++; $display("FAIL ar_after got=%h exp=AB", data_o); end
    checks++; if (count_o !== 7'd1) begin errors++; $display("FAIL ar_after_count got=%0d exp=1", count_o); end
    pop_one();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ar_final_empty got=%b exp=1", empty_o); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset_i      = 1'b1;
    write_enable = 1'b0;
    write_data   = '0;
    write_width  = '0;
    ack          = 1'b0;
    test_reset();
    test_word_order();
    test_mixed_widths();
    test_rotation();
    test_full();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
